// File: rtl/multi_door_occupancy_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_door_occupancy_ctrl_if
// Description : Sensor inputs and occupancy/lighting outputs of the
//               multi-door occupancy controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_door_occupancy_ctrl_if #(
    parameter int N_DOORS = 2,
    parameter int CNT_W   = 8,
    parameter int N_ZONES = 5
);
    logic [N_DOORS-1:0] entry_sensor;
    logic [N_DOORS-1:0] exit_sensor;
    logic               force_on;
    logic               clr_err;
    logic [CNT_W-1:0]   occupancy_count;
    logic [N_ZONES-1:0] leds;
    logic               full;
    logic               empty;
    logic               err;

    modport master (
        output entry_sensor, exit_sensor, force_on, clr_err,
        input  occupancy_count, leds, full, empty, err
    );

    modport slave (
        input  entry_sensor, exit_sensor, force_on, clr_err,
        output occupancy_count, leds, full, empty, err
    );
endinterface
`default_nettype wire

// File: rtl/multi_door_occupancy_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multi_door_occupancy_ctrl
// Description : Debounced multi-door people counter with saturating occupancy
//               count and a thermometer-coded lighting FSM with off-delay.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_door_occupancy_ctrl #(
    parameter int N_DOORS    = 2,
    parameter int CNT_W      = 8,
    parameter int MAX_OCC    = 99,
    parameter int DEB_CYCLES = 50000,
    parameter int N_ZONES    = 5,
    parameter int OFF_DELAY  = 1000000
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    multi_door_occupancy_ctrl_if.slave bus
);
    localparam int c_N_CH   = 2 * N_DOORS;
    localparam int c_DEB_W  = $clog2(DEB_CYCLES);
    localparam int c_HOLD_W = (OFF_DELAY > 1) ? $clog2(OFF_DELAY) : 1;
    localparam int c_SUM_W  = CNT_W + 5;
    localparam int c_PROD_W = 2 * CNT_W + 1;
    localparam logic signed [c_SUM_W-1:0] c_MAX_S = c_SUM_W'(MAX_OCC);

    localparam logic [1:0] c_ST_OFF  = 2'd0;
    localparam logic [1:0] c_ST_ON   = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    // Channels [N_DOORS-1:0] are entry beams, the upper half exit beams.
    logic [c_N_CH-1:0] w_raw;
    logic [c_N_CH-1:0] r_sync1;
    logic [c_N_CH-1:0] r_sync2;
    logic [c_N_CH-1:0] w_deb;
    logic [c_N_CH-1:0] r_deb_d;
    logic [c_N_CH-1:0] w_evt;

    assign w_raw = {bus.exit_sensor, bus.entry_sensor};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb_d <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= w_deb;
        end
    end

    for (genvar i = 0; i < c_N_CH; i++) begin : g_deb
        logic [c_DEB_W-1:0] r_cnt;
        logic               r_lvl;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (r_sync2[i] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DEB_W'(DEB_CYCLES - 1)) begin
                r_cnt <= '0;
                r_lvl <= r_sync2[i];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_deb[i] = r_lvl;
    end

    assign w_evt = w_deb & ~r_deb_d;

    logic [3:0]                w_n_ent;
    logic [3:0]                w_n_ext;
    logic signed [c_SUM_W-1:0] w_sum;
    logic [CNT_W-1:0]          w_count_next;
    logic                      w_clamp;
    logic [CNT_W-1:0]          r_count;
    logic                      r_err;

    always_comb begin
        w_n_ent = '0;
        w_n_ext = '0;
        for (int i = 0; i < N_DOORS; i++) begin
            w_n_ent = w_n_ent + {3'b000, w_evt[i]};
            w_n_ext = w_n_ext + {3'b000, w_evt[N_DOORS + i]};
        end
    end

    // Wide signed sum so several simultaneous exits at 0 cannot wrap.
    always_comb begin
        w_sum = $signed({{(c_SUM_W - CNT_W){1'b0}}, r_count})
              + $signed({{(c_SUM_W - 4){1'b0}}, w_n_ent})
              - $signed({{(c_SUM_W - 4){1'b0}}, w_n_ext});
        w_clamp      = 1'b0;
        w_count_next = w_sum[CNT_W-1:0];
        if (w_sum < 0) begin
            w_clamp      = 1'b1;
            w_count_next = '0;
        end else if (w_sum > c_MAX_S) begin
            w_clamp      = 1'b1;
            w_count_next = CNT_W'(MAX_OCC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (w_clamp) begin
                r_err <= 1'b1;
            end else if (bus.clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_PROD_W-1:0] w_scaled;
    logic [N_ZONES-1:0]  w_therm;
    logic [N_ZONES-1:0]  w_leds_next;
    logic [N_ZONES-1:0]  r_leds;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_OFF;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_ST_HOLD && w_state_next == c_ST_HOLD) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_OFF:  if (r_count != '0) w_state_next = c_ST_ON;
            c_ST_ON:   if (r_count == '0) w_state_next = c_ST_HOLD;
            c_ST_HOLD: begin
                if (r_count != '0) begin
                    w_state_next = c_ST_ON;
                end else if (r_hold_cnt == c_HOLD_W'(OFF_DELAY - 1)) begin
                    w_state_next = c_ST_OFF;
                end
            end
            default:   w_state_next = c_ST_OFF;
        endcase
    end

    assign w_scaled = c_PROD_W'(r_count) * c_PROD_W'(N_ZONES);

    for (genvar k = 0; k < N_ZONES; k++) begin : g_therm
        assign w_therm[k] = (w_scaled > c_PROD_W'(k * MAX_OCC));
    end

    // Decoding the next state keeps the lamp lit across the ON->HOLD edge.
    always_comb begin
        w_leds_next = '0;
        case (w_state_next)
            c_ST_ON:   w_leds_next = w_therm;
            c_ST_HOLD: w_leds_next = N_ZONES'(1);
            default:   w_leds_next = '0;
        endcase
        if (bus.force_on) begin
            w_leds_next = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds <= '0;
        end else begin
            r_leds <= w_leds_next;
        end
    end

    assign bus.occupancy_count = r_count;
    assign bus.leds            = r_leds;
    assign bus.err             = r_err;
    assign bus.full            = (r_count == CNT_W'(MAX_OCC));
    assign bus.empty           = (r_count == '0);
endmodule
`default_nettype wire
